cla_adder32: RTL and testbench
==============================

Name: cla_adder32

Overview:
- Registered two-level carry-lookahead adder used by the pipelined ALU for add and subtract.
- Subtract is performed by the ALU feeding ~B with Cin=1.
- Computes S = A + B + Cin over WIDTH bits, plus carry-out and signed-overflow flags.
- The sum path is built from 4-bit CLA groups joined by a second-level lookahead unit. The `+` operator is not permitted on the sum path.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of 4 and ≤ 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A (two's complement or unsigned).
- B  input  WIDTH  operand B.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered sum, (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry out of bit WIDTH-1.
- Ovf  output  1  registered signed overflow.

Behaviour:
- Reset:
  - While n_rst = 0, S, Cout and Ovf are forced to 0 immediately, independent of clk.
  - Registers hold 0 until the first rising edge after n_rst deasserts.
- Bit level, per bit i:
  - g_i = A_i & B_i
  - p_i = A_i ^ B_i
  - sum_i = p_i ^ c_i
- Group level (4-bit group k):
  - Internal carries c1..c3 come from lookahead equations on g, p and the group carry-in.
  - Group generate GG_k = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group propagate GP_k = p3p2p1p0.
- Second level:
  - The lookahead unit computes the carry-in of every group directly from GG, GP and Cin. No ripple between groups.
  - The carry into group 0 is Cin.
  - Cout = carry out of the top group.
- Ovf = carry into MSB XOR carry out of MSB. This equals 1 when A and B have the same sign and the sum's sign differs.
- Latency:
  - The combinational result is captured every rising edge. S, Cout and Ovf reflect the inputs present at the previous edge (1 cycle).
  - No enable and no handshake: a new operation is accepted every cycle.
- Wrap-around: the result is mod 2^WIDTH. Cout flags the unsigned carry; the sum is never saturated.
- Reset mid-operation: any in-flight result is discarded. Outputs go to 0 and the first valid result appears one edge after reset release.
- Inputs containing X propagate X to the outputs. No sanitisation is required.

Optional Feature:
- Macro: CLA_INREG_EN.
- When defined:
  - A, B and Cin are first captured in input registers (reset to 0 asynchronously by n_rst).
  - The lookahead logic operates on the registered values.
  - Latency becomes 2 cycles, with throughput still 1 per cycle.
- When undefined: no input registers; latency is 1 cycle as above.
- Ports and arithmetic are identical in both builds.

Test Plan:
- Reset: assert n_rst=0 mid-cycle with nonzero S → S=0, Cout=0, Ovf=0 immediately. Release, apply A=1, B=1, Cin=1 → after latency S=3, Cout=0, Ovf=0.
- Basic sums:
  - A=15, B=27, Cin=1 → S=43, Cout=0.
  - A=5987, B=1249, Cin=1 → S=7237, Cout=0.
- Unsigned carry with negative operand: A=0xFFFFFFFF, B=27, Cin=0 → S=26 (0x1A), Cout=1, Ovf=0.
- Two negatives:
  - A=-17 (0xFFFFFFEF), B=-468 (0xFFFFFE2C), Cin=0 → S=0xFFFFFE1B (-485), Cout=1, Ovf=0.
  - A=0x80000000, B=0x80000000 → S=0, Cout=1, Ovf=1.
- Full-width carry chain:
  - A=0xFFFFFFFF, B=1, Cin=0 → S=0, Cout=1, Ovf=0.
  - A=0x7FFFFFFF, B=0, Cin=1 → S=0x80000000, Ovf=1.
  - A=0, B=0, Cin=0 → S=0, Cout=0.
- Back-to-back throughput: change operands every cycle for 1000 random vectors. Each output matches the golden (A+B+Cin) from exactly 1 cycle earlier, or 2 cycles earlier with CLA_INREG_EN. Covers both builds.

Source files
------------

// File: rtl/cla_adder32.sv
// Registered two-level carry-lookahead adder: S = A + B + Cin, with carry-out and signed overflow.
// Latency 1 cycle (2 cycles with CLA_INREG_EN); one new operation accepted every cycle.
// No backpressure: free-running pipeline, no enable or handshake.
//
// Ports:
//    clk    rising-edge clock
//    n_rst  asynchronous active-low reset, clears every register
//    A, B   WIDTH-bit operands (unsigned or two's complement)
//    Cin    carry into bit 0 (subtract = ~B with Cin = 1, done by the ALU)
//    S      registered sum, (A + B + Cin) mod 2^WIDTH
//    Cout   registered carry out of bit WIDTH-1
//    Ovf    registered signed overflow (carry into MSB xor carry out of MSB)
//
// Build option: define CLA_INREG_EN to register A, B and Cin before the
// lookahead logic (latency 2, throughput unchanged).
//
// WIDTH must be a multiple of 4 and no larger than 64.

module cla_adder32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NG = WIDTH / 4;

   // Operands actually seen by the lookahead logic
   logic [WIDTH-1:0] a_op;
   logic [WIDTH-1:0] b_op;
   logic             cin_op;

`ifdef CLA_INREG_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else begin
         a_q   <= A;
         b_q   <= B;
         cin_q <= Cin;
      end
   end

   assign a_op   = a_q;
   assign b_op   = b_q;
   assign cin_op = cin_q;
`else
   assign a_op   = A;
   assign b_op   = B;
   assign cin_op = Cin;
`endif

   // Bit-level generate / propagate
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   // c[i] is the carry into bit i
   logic [WIDTH-1:0] c;

   assign g = a_op & b_op;
   assign p = a_op ^ b_op;

   // Group-level generate / propagate, and the carry into each group.
   // gc[NG] is the carry out of the top group.
   logic [NG-1:0] gg;
   logic [NG-1:0] gp;
   logic [NG:0]   gc;

   // First level: 4-bit CLA groups. Internal carries are flat
   // sum-of-products of g, p and the group carry-in.
   for (genvar k = 0; k < NG; k++) begin : g_grp
      localparam int B0 = 4 * k;

      assign c[B0]   = gc[k];
      assign c[B0+1] = g[B0]
                     | (p[B0] & gc[k]);
      assign c[B0+2] = g[B0+1]
                     | (p[B0+1] & g[B0])
                     | (p[B0+1] & p[B0] & gc[k]);
      assign c[B0+3] = g[B0+2]
                     | (p[B0+2] & g[B0+1])
                     | (p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+2] & p[B0+1] & p[B0] & gc[k]);

      assign gg[k] = g[B0+3]
                   | (p[B0+3] & g[B0+2])
                   | (p[B0+3] & p[B0+2] & g[B0+1])
                   | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      assign gp[k] = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];
   end

   // Second level: each group carry-in is its own sum-of-products over
   // GG/GP of all lower groups and Cin, i.e.
   //   gc[k] = GG[k-1] | GP[k-1]GG[k-2] | ... | GP[k-1]..GP[0]Cin
   // The loop only enumerates the product terms; no term uses gc[k-1],
   // so there is no ripple between groups.
   always_comb begin
      logic acc;
      logic prod;
      acc   = 1'b0;
      prod  = 1'b1;
      gc    = '0;
      gc[0] = cin_op;
      for (int k = 1; k <= NG; k++) begin
         acc  = 1'b0;
         prod = 1'b1;
         for (int j = k - 1; j >= 0; j--) begin
            acc  = acc | (prod & gg[j]);
            prod = prod & gp[j];
         end
         gc[k] = acc | (prod & cin_op);
      end
   end

   logic [WIDTH-1:0] sum_c;
   logic             cout_c;
   logic             ovf_c;

   assign sum_c  = p ^ c;
   assign cout_c = gc[NG];
   // Signed overflow: carry into the MSB disagrees with carry out of it
   assign ovf_c  = c[WIDTH-1] ^ gc[NG];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         S    <= '0;
         Cout <= 1'b0;
         Ovf  <= 1'b0;
      end else begin
         S    <= sum_c;
         Cout <= cout_c;
         Ovf  <= ovf_c;
      end
   end

endmodule

// File: tb/tb_cla_adder32.sv
// Self-checking bench for cla_adder32: directed vectors plus a back-to-back random stream.
// Expected values are hand-computed constants or a 33-bit reference sum.
// Latency follows the build: 1 cycle, or 2 with CLA_INREG_EN.

module tb_cla_adder32;

`ifdef CLA_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam int N_B2B = 1000;

   logic        clk;
   logic        n_rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [31:0] s;
   logic        cout;
   logic        ovf;

   int passed = 0;
   int total  = 0;

   cla_adder32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .A     (a),
      .B     (b),
      .Cin   (cin),
      .S     (s),
      .Cout  (cout),
      .Ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc);
      a   = va;
      b   = vb;
      cin = vc;
   endtask

   // Advance to just after the edge that presents the result of the driven inputs
   task automatic wait_result();
      repeat (LAT) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Held in reset from time 0: outputs must be 0 before any clock edge
      #3;
      total++;
      if ({s, cout, ovf} !== 34'd0) $display("FAIL reset_initial got s=%h cout=%b ovf=%b want 0/0/0", s, cout, ovf);
      else passed++;

      @(posedge clk);
      #1;
      n_rst = 1'b1;
      drive(32'h0000_1234, 32'h0000_1111, 1'b0);
      wait_result();
      total++;
      if (s !== 32'h0000_2345) $display("FAIL pre_reset_sum got %h want %h", s, 32'h0000_2345);
      else passed++;

      // Mid-cycle reset with a nonzero result: outputs clear without a clock edge
      #2;
      n_rst = 1'b0;
      #1;
      total++;
      if (s !== 32'd0) $display("FAIL reset_async_s got %h want 0", s);
      else passed++;
      total++;
      if (cout !== 1'b0) $display("FAIL reset_async_cout got %b want 0", cout);
      else passed++;
      total++;
      if (ovf !== 1'b0) $display("FAIL reset_async_ovf got %b want 0", ovf);
      else passed++;

      @(negedge clk);
      n_rst = 1'b1;
      drive(32'd1, 32'd1, 1'b1);
      @(posedge clk);
      #1;
      if (LAT > 1) wait_result_rest();
      total++;
      if (s !== 32'd3) $display("FAIL reset_release_s got %h want %h", s, 32'd3);
      else passed++;
      total++;
      if (cout !== 1'b0) $display("FAIL reset_release_cout got %b want 0", cout);
      else passed++;
      total++;
      if (ovf !== 1'b0) $display("FAIL reset_release_ovf got %b want 0", ovf);
      else passed++;
   endtask

   // Remaining edges after the first one when latency exceeds 1
   task automatic wait_result_rest();
      repeat (LAT - 1) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      logic [31:0] ta [2];
      logic [31:0] tb [2];
      logic        tc [2];
      logic [31:0] es [2];
      ta = '{32'd15, 32'd5987};
      tb = '{32'd27, 32'd1249};
      tc = '{1'b1,   1'b1};
      es = '{32'd43, 32'd7237};
      for (int i = 0; i < 2; i++) begin
         drive(ta[i], tb[i], tc[i]);
         wait_result();
         total++;
         if (s !== es[i]) $display("FAIL basic%0d_s got %h want %h", i, s, es[i]);
         else passed++;
         total++;
         if (cout !== 1'b0) $display("FAIL basic%0d_cout got %b want 0", i, cout);
         else passed++;
         total++;
         if (ovf !== 1'b0) $display("FAIL basic%0d_ovf got %b want 0", i, ovf);
         else passed++;
      end
   endtask

   task automatic test_negatives();
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic [31:0] es [3];
      logic        ec [3];
      logic        eo [3];
      ta = '{32'hFFFF_FFFF, 32'hFFFF_FFEF, 32'h8000_0000};
      tb = '{32'd27,        32'hFFFF_FE2C, 32'h8000_0000};
      es = '{32'h0000_001A, 32'hFFFF_FE1B, 32'h0000_0000};
      ec = '{1'b1, 1'b1, 1'b1};
      eo = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(ta[i], tb[i], 1'b0);
         wait_result();
         total++;
         if (s !== es[i]) $display("FAIL neg%0d_s got %h want %h", i, s, es[i]);
         else passed++;
         total++;
         if (cout !== ec[i]) $display("FAIL neg%0d_cout got %b want %b", i, cout, ec[i]);
         else passed++;
         total++;
         if (ovf !== eo[i]) $display("FAIL neg%0d_ovf got %b want %b", i, ovf, eo[i]);
         else passed++;
      end
   endtask

   task automatic test_carry_chain();
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic        tc [3];
      logic [31:0] es [3];
      logic        ec [3];
      logic        eo [3];
      ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
      tb = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
      tc = '{1'b0, 1'b1, 1'b0};
      es = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
      ec = '{1'b1, 1'b0, 1'b0};
      eo = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(ta[i], tb[i], tc[i]);
         wait_result();
         total++;
         if (s !== es[i]) $display("FAIL chain%0d_s got %h want %h", i, s, es[i]);
         else passed++;
         total++;
         if (cout !== ec[i]) $display("FAIL chain%0d_cout got %b want %b", i, cout, ec[i]);
         else passed++;
         total++;
         if (ovf !== eo[i]) $display("FAIL chain%0d_ovf got %b want %b", i, ovf, eo[i]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] es [N_B2B];
      logic        ec [N_B2B];
      logic        eo [N_B2B];
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [32:0] full;
      for (int i = 0; i < N_B2B + LAT; i++) begin
         if (i >= LAT) begin
            total++;
            if (s !== es[i-LAT]) $display("FAIL b2b%0d_s got %h want %h", i - LAT, s, es[i-LAT]);
            else passed++;
            total++;
            if (cout !== ec[i-LAT]) $display("FAIL b2b%0d_cout got %b want %b", i - LAT, cout, ec[i-LAT]);
            else passed++;
            total++;
            if (ovf !== eo[i-LAT]) $display("FAIL b2b%0d_ovf got %b want %b", i - LAT, ovf, eo[i-LAT]);
            else passed++;
         end
         if (i < N_B2B) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            full  = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            es[i] = full[31:0];
            ec[i] = full[32];
            eo[i] = (ra[31] == rb[31]) && (full[31] != ra[31]);
            drive(ra, rb, rc);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_rst = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      test_reset();
      test_basic();
      test_negatives();
      test_carry_chain();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
